word_stats: RTL and testbench

- Downstream consumer of the 16-bit word stream produced by the dual-clock buffer stage, placed in the read-clock domain.
- Accumulates consecutive valid words into fixed windows of 2**WIN_LOG2 words.
- At the end of each window it reports sum, minimum, maximum, average and sample count with a one-cycle result strobe.
- A flush input forces early reporting of a partial window.

---
 rtl/word_stats.sv | 182 ++++++++++++++++++
 tb/tb_word_stats.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/word_stats.sv
// word_stats: windowed statistics over an unsigned word stream.
//
// Groups consecutive accepted words into windows of 2**WIN_LOG2 words. When a
// window closes it reports sum, min, max, average and word count. A window
// closes when it is full, or early when flush is asserted. The result outputs
// are registered and hold their values until the next window closes.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   in_data carries a word this cycle
//   in_data    unsigned input word
//   flush      close the current window early (word on the same edge included)
//   busy       a window is open (ACCUM state)
//   res_valid  one-cycle strobe marking new results
//   res_sum    sum of the window's words
//   res_min    smallest word of the window
//   res_max    largest word of the window
//   res_avg    res_sum >> WIN_LOG2 (true mean only for full windows)
//   res_count  number of words in the reported window, 1..WIN
module word_stats #(
    parameter int DATA_W   = 16,
    parameter int WIN_LOG2 = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         flush,
    output logic                         busy,
    output logic                         res_valid,
    output logic [DATA_W+WIN_LOG2-1:0]   res_sum,
    output logic [DATA_W-1:0]            res_min,
    output logic [DATA_W-1:0]            res_max,
    output logic [DATA_W-1:0]            res_avg,
    output logic [WIN_LOG2:0]            res_count
);

    localparam int SUM_W = DATA_W + WIN_LOG2;
    localparam int CNT_W = WIN_LOG2 + 1;
    localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(1) << WIN_LOG2;
    localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Unsigned minimum of two words.
    function automatic logic [DATA_W-1:0] umin(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Unsigned maximum of two words.
    function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic [SUM_W-1:0]    acc_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [DATA_W-1:0]   min_r;
    logic [DATA_W-1:0]   max_r;

    // Window contents including the word accepted on this edge (if any).
    logic [SUM_W-1:0]    acc_w_s;
    logic [CNT_W-1:0]    cnt_w_s;
    logic [DATA_W-1:0]   min_w_s;
    logic [DATA_W-1:0]   max_w_s;
    logic                close_s;

    logic                busy_r;
    logic                res_valid_r;
    logic [SUM_W-1:0]    res_sum_r;
    logic [DATA_W-1:0]   res_min_r;
    logic [DATA_W-1:0]   res_max_r;
    logic [DATA_W-1:0]   res_avg_r;
    logic [CNT_W-1:0]    res_count_r;

    // Fold the incoming word into the running window and decide whether it closes.
    always_comb begin
        acc_w_s = acc_r;
        cnt_w_s = cnt_r;
        min_w_s = min_r;
        max_w_s = max_r;
        if (in_valid) begin
            if (state_r == IDLE) begin
                acc_w_s = SUM_W'(in_data);
                cnt_w_s = CNT_W'(1);
                min_w_s = in_data;
                max_w_s = in_data;
            end else begin
                acc_w_s = acc_r + SUM_W'(in_data);
                cnt_w_s = cnt_r + CNT_W'(1);
                min_w_s = umin(min_r, in_data);
                max_w_s = umax(max_r, in_data);
            end
        end else begin
            acc_w_s = acc_r;
            cnt_w_s = cnt_r;
            min_w_s = min_r;
            max_w_s = max_r;
        end
        // A non-zero count means there is something to report, so flush in an
        // empty IDLE is ignored; a full window and flush together close once.
        close_s = (in_valid && (cnt_w_s == WIN_CNT)) ||
                  (flush && (cnt_w_s != CNT_W'(0)));
    end

    // Next-state logic of the window FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid && !close_s) begin
                    state_nxt_s = ACCUM;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCUM: begin
                if (close_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register, window accumulators and registered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            acc_r       <= {SUM_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            min_r       <= ALL_ONES;
            max_r       <= {DATA_W{1'b0}};
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
            res_sum_r   <= {SUM_W{1'b0}};
            res_min_r   <= {DATA_W{1'b0}};
            res_max_r   <= {DATA_W{1'b0}};
            res_avg_r   <= {DATA_W{1'b0}};
            res_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ACCUM);
            if (close_s) begin
                acc_r       <= {SUM_W{1'b0}};
                cnt_r       <= {CNT_W{1'b0}};
                min_r       <= ALL_ONES;
                max_r       <= {DATA_W{1'b0}};
                res_valid_r <= 1'b1;
                res_sum_r   <= acc_w_s;
                res_min_r   <= min_w_s;
                res_max_r   <= max_w_s;
                res_avg_r   <= acc_w_s[SUM_W-1:WIN_LOG2];
                res_count_r <= cnt_w_s;
            end else begin
                acc_r       <= acc_w_s;
                cnt_r       <= cnt_w_s;
                min_r       <= min_w_s;
                max_r       <= max_w_s;
                res_valid_r <= 1'b0;
            end
        end
    end

    assign busy      = busy_r;
    assign res_valid = res_valid_r;
    assign res_sum   = res_sum_r;
    assign res_min   = res_min_r;
    assign res_max   = res_max_r;
    assign res_avg   = res_avg_r;
    assign res_count = res_count_r;

endmodule

// File: tb/tb_word_stats.sv
// Testbench for word_stats (DATA_W=16, WIN_LOG2=3). Directed scenarios plus a
// randomized phase, all checked cycle by cycle against a queue-based window
// model that computes statistics directly from the buffered words.
module tb_word_stats;

    localparam int DATA_W   = 16;
    localparam int WIN_LOG2 = 3;
    localparam int WIN      = 8;

    logic                       clk;
    logic                       rst;
    logic                       in_valid;
    logic [DATA_W-1:0]          in_data;
    logic                       flush;
    logic                       busy;
    logic                       res_valid;
    logic [DATA_W+WIN_LOG2-1:0] res_sum;
    logic [DATA_W-1:0]          res_min;
    logic [DATA_W-1:0]          res_max;
    logic [DATA_W-1:0]          res_avg;
    logic [WIN_LOG2:0]          res_count;

    word_stats #(.DATA_W(DATA_W), .WIN_LOG2(WIN_LOG2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .flush     (flush),
        .busy      (busy),
        .res_valid (res_valid),
        .res_sum   (res_sum),
        .res_min   (res_min),
        .res_max   (res_max),
        .res_avg   (res_avg),
        .res_count (res_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: words of the open window plus the last reported results.
    int unsigned win_q[$];
    int unsigned e_sum, e_min, e_max, e_avg, e_cnt;
    bit          e_valid, e_busy;
    int          pulses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("res_valid", {31'd0, res_valid}, {31'd0, e_valid});
        chk("busy",      {31'd0, busy},      {31'd0, e_busy});
        chk("res_sum",   {13'd0, res_sum},   e_sum);
        chk("res_min",   {16'd0, res_min},   e_min);
        chk("res_max",   {16'd0, res_max},   e_max);
        chk("res_avg",   {16'd0, res_avg},   e_avg);
        chk("res_count", {28'd0, res_count}, e_cnt);
    endtask

    task automatic model_clear();
        win_q.delete();
        e_sum = 0; e_min = 0; e_max = 0; e_avg = 0; e_cnt = 0;
        e_valid = 1'b0; e_busy = 1'b0;
    endtask

    // Apply one cycle of inputs, advance the model, then check after the edge.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic f);
        int unsigned s, mn, mx;
        in_valid = v;
        in_data  = d;
        flush    = f;
        if (v) win_q.push_back(int'(d));
        e_valid = 1'b0;
        if ((v && win_q.size() == WIN) || (f && win_q.size() > 0)) begin
            s = 0; mn = 32'hFFFF_FFFF; mx = 0;
            foreach (win_q[i]) begin
                s += win_q[i];
                if (win_q[i] < mn) mn = win_q[i];
                if (win_q[i] > mx) mx = win_q[i];
            end
            e_sum = s; e_min = mn; e_max = mx;
            e_avg = s / WIN;
            e_cnt = win_q.size();
            e_valid = 1'b1;
            win_q.delete();
        end
        e_busy = (win_q.size() > 0);
        @(posedge clk);
        #1;
        check_all();
        if (res_valid) pulses++;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0;
        pulses = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Words 1..8 back to back.
        for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0);
        chk("seq_sum",   {13'd0, res_sum}, 32'd36);
        chk("seq_min",   {16'd0, res_min}, 32'd1);
        chk("seq_max",   {16'd0, res_max}, 32'd8);
        chk("seq_avg",   {16'd0, res_avg}, 32'd4);
        chk("seq_count", {28'd0, res_count}, 32'd8);
        step(1'b0, 16'd0, 1'b0);

        // Sixteen words of 0x0010: two windows, no bubble between them.
        pulses = 0;
        for (int i = 0; i < 16; i++) step(1'b1, 16'h0010, 1'b0);
        chk("b2b_pulses", 32'(pulses), 32'd2);
        chk("b2b_sum", {13'd0, res_sum}, 32'h80);
        step(1'b0, 16'd0, 1'b0);

        // Eight 0xFFFF words with random idle gaps.
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) step(1'b0, 16'($urandom), 1'b0);
            step(1'b1, 16'hFFFF, 1'b0);
        end
        chk("max_sum", {13'd0, res_sum}, 32'h7FFF8);
        chk("max_avg", {16'd0, res_avg}, 32'hFFFF);

        // Partial window closed by flush on the edge of its last word.
        step(1'b1, 16'd5, 1'b0);
        step(1'b1, 16'd2, 1'b0);
        step(1'b1, 16'd9, 1'b1);
        chk("flush_count", {28'd0, res_count}, 32'd3);
        chk("flush_sum",   {13'd0, res_sum},   32'd16);
        chk("flush_avg",   {16'd0, res_avg},   32'd2);
        // Flush in idle without data, flush with a lone word, flush on the 8th word.
        step(1'b0, 16'd0, 1'b1);
        step(1'b1, 16'd77, 1'b1);
        pulses = 0;
        for (int i = 0; i < 8; i++) step(1'b1, 16'(100 + i), (i == 7) ? 1'b1 : 1'b0);
        step(1'b0, 16'd0, 1'b0);
        chk("full_flush_pulses", 32'(pulses), 32'd1);
        // Flush with no word on the edge, mid window.
        step(1'b1, 16'd40, 1'b0);
        step(1'b1, 16'd20, 1'b0);
        step(1'b0, 16'd0, 1'b1);
        step(1'b0, 16'd0, 1'b0);

        // Reset in the middle of a window, asynchronously.
        for (int i = 0; i < 4; i++) step(1'b1, 16'(1000 + i), 1'b0);
        in_valid = 1'b0; flush = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        model_clear();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, 16'd3, 1'b0);
        chk("rst_sum",   {13'd0, res_sum},   32'd24);
        chk("rst_min",   {16'd0, res_min},   32'd3);
        chk("rst_max",   {16'd0, res_max},   32'd3);
        chk("rst_count", {28'd0, res_count}, 32'd8);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [DATA_W-1:0] d;
            case ($urandom_range(0, 5))
                0:       d = 16'h0000;
                1:       d = 16'hFFFF;
                default: d = 16'($urandom);
            endcase
            step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, d,
                 ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
